fighter_ctrl: RTL and testbench



---
 rtl/fighter_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fighter_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fighter_ctrl.sv
// Per-player fighter controller: turns debounced buttons into position, facing,
// animation state, health and attack requests, one update per frame tick.
module fighter_ctrl #(
   parameter int X_MIN         = 1,
   parameter int X_MAX         = 127,
   parameter int P0_X          = 107,
   parameter int P1_X          = 10,
   parameter int GROUND_LEVEL  = 100,
   parameter int Y_MIN         = 20,
   parameter int JUMP_V        = 7,
   parameter int MAX_FALL      = 7,
   parameter int WALK_SPEED    = 1,
   parameter int CROUCH_DIV    = 4,
   parameter int MELEE_TICKS   = 15,
   parameter int HITSTUN_TICKS = 12,
   parameter int KNOCKBACK     = 4,
   parameter int HEALTH_MAX    = 100,
   parameter int FB_DMG        = 10,
   parameter int MELEE_DMG     = 8,
   parameter int BLOCK_DMG     = 1,
   parameter int FB_COOLDOWN   = 30
) (
   input  logic       clk,
   input  logic       start_n,
   input  logic       tick,
   input  logic       left,
   input  logic       right,
   input  logic       up,
   input  logic       down,
   input  logic       a,
   input  logic       b,
   input  logic       hit_fireball,
   input  logic       hit_melee,
   input  logic       player_number,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [2:0] state,
   output logic       direction,
   output logic       fireball_fire,
   output logic       melee_active,
   output logic [7:0] health,
   output logic       ko
);

   typedef enum logic [2:0] {
      IDLE = 3'd0, JUMP = 3'd1, CROUCH = 3'd2, MELEE_L = 3'd3,
      MELEE_R = 3'd4, HIT = 3'd5, BLOCK = 3'd6, KO = 3'd7
   } state_t;

   localparam logic signed [5:0] VY_JUMP = -(6'(JUMP_V));

   state_t            st_q, st_n;
   logic [9:0]        x_q, x_n, y_q, y_n, step;
   logic signed [5:0] vy_q, vy_n, fall_vy, jump_vy;
   logic [9:0]        fall_y, jump_y;
   logic              dir_q, dir_n, a_q, b_q, ff_q, fire_n, mact_q, ko_q;
   logic [7:0]        hp_q, hp_n, stun_q, stun_n, mel_q, mel_n;
   logic [7:0]        cd_q, cd_n, cd_dec, div_q, div_n, div_wrap;
   logic [8:0]        dmg;
   logic              on_ground, crouching, a_rise, b_rise, blocked;

   function automatic logic [9:0] move_left(input logic [9:0] xi, input logic [9:0] d);
      if ({1'b0, xi} < 11'(X_MIN) + {1'b0, d}) return 10'(X_MIN);
      else return xi - d;
   endfunction

   function automatic logic [9:0] move_right(input logic [9:0] xi, input logic [9:0] d);
      if ({1'b0, xi} + {1'b0, d} > 11'(X_MAX)) return 10'(X_MAX);
      else return xi + d;
   endfunction

   function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [8:0] d);
      if ({1'b0, hp} > d) return hp - 8'(d);
      else return 8'd0;
   endfunction

   // One airborne step: move by vy, then accelerate toward MAX_FALL; floor/ceiling stop it.
   function automatic logic [15:0] phys(input logic [9:0] yi, input logic signed [5:0] vi);
      logic signed [11:0] ys;
      ys = $signed({2'b00, yi}) + $signed({{6{vi[5]}}, vi});
      if (ys >= $signed(12'(GROUND_LEVEL))) return {10'(GROUND_LEVEL), 6'd0};
      else if (ys < $signed(12'(Y_MIN)))    return {10'(Y_MIN), 6'd0};
      else if (vi >= $signed(6'(MAX_FALL))) return {10'(ys), 6'(MAX_FALL)};
      else return {10'(ys), 6'(vi + 6'sd1)};
   endfunction

   function automatic state_t free_state(input logic [9:0] yi, input logic signed [5:0] vi,
                                         input logic dn);
      if (yi != 10'(GROUND_LEVEL) || vi != 6'sd0) return JUMP;
      else if (dn) return CROUCH;
      else return IDLE;
   endfunction

   assign on_ground = (y_q == 10'(GROUND_LEVEL)) && (vy_q == 6'sd0);
   assign crouching = on_ground && down && !up;
   assign a_rise    = a && !a_q;
   assign b_rise    = b && !b_q;
   assign cd_dec    = (cd_q != 8'd0) ? cd_q - 8'd1 : 8'd0;
   assign div_wrap  = (div_q == 8'(CROUCH_DIV - 1)) ? 8'd0 : div_q + 8'd1;
   assign {fall_y, fall_vy} = on_ground ? {y_q, vy_q} : phys(y_q, vy_q);
   assign {jump_y, jump_vy} = phys(y_q, VY_JUMP);

   always_comb begin
      x_n = x_q; y_n = y_q; vy_n = vy_q; dir_n = dir_q; st_n = st_q;
      hp_n = hp_q; stun_n = stun_q; mel_n = mel_q; cd_n = cd_q; div_n = div_q;
      fire_n = 1'b0; dmg = 9'd0; blocked = 1'b0; step = 10'd0;
      if (st_q != KO) begin
         div_n = div_wrap;
         cd_n  = cd_dec;
         if (hit_fireball || hit_melee) begin
            blocked = on_ground && down && (stun_q == 8'd0) && (mel_q == 8'd0);
            if (blocked) begin
               dmg  = (hit_fireball ? 9'(BLOCK_DMG) : 9'd0) + (hit_melee ? 9'(BLOCK_DMG) : 9'd0);
               st_n = BLOCK;
            end else begin
               dmg    = (hit_fireball ? 9'(FB_DMG) : 9'd0) + (hit_melee ? 9'(MELEE_DMG) : 9'd0);
               stun_n = 8'(HITSTUN_TICKS);
               mel_n  = 8'd0;
               st_n   = HIT;
               x_n    = dir_q ? move_left(x_q, 10'(KNOCKBACK)) : move_right(x_q, 10'(KNOCKBACK));
               y_n    = fall_y;
               vy_n   = fall_vy;
            end
            hp_n = sat_sub(hp_q, dmg);
            if (hp_n == 8'd0) st_n = KO;
         end else if (stun_q != 8'd0) begin
            stun_n = stun_q - 8'd1;
            y_n    = fall_y;
            vy_n   = fall_vy;
            st_n   = (stun_n != 8'd0) ? HIT : free_state(fall_y, fall_vy, down);
         end else begin
            fire_n = a_rise && (cd_dec == 8'd0);
            if (mel_q != 8'd0) begin
               mel_n = mel_q - 8'd1;
               if (mel_n == 8'd0) st_n = free_state(y_q, vy_q, down);
            end else if (b_rise && on_ground && !crouching) begin
               mel_n = 8'(MELEE_TICKS);
               st_n  = dir_q ? MELEE_R : MELEE_L;
            end else begin
               // Crouch-walking only steps on the divider wrap.
               if (crouching) step = (div_wrap == 8'd0) ? 10'd1 : 10'd0;
               else           step = 10'(WALK_SPEED);
               if (left) begin
                  dir_n = 1'b0;
                  x_n   = move_left(x_q, step);
               end else if (right) begin
                  dir_n = 1'b1;
                  x_n   = move_right(x_q, step);
               end
               if (on_ground && up) {y_n, vy_n} = {jump_y, jump_vy};
               else                 {y_n, vy_n} = {fall_y, fall_vy};
               st_n = free_state(y_n, vy_n, down);
            end
            if (fire_n) cd_n = 8'(FB_COOLDOWN);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!start_n) begin
         x_q    <= player_number ? 10'(P1_X) : 10'(P0_X);
         dir_q  <= player_number;
         y_q    <= 10'(GROUND_LEVEL);
         vy_q   <= 6'sd0;
         st_q   <= IDLE;
         hp_q   <= 8'(HEALTH_MAX);
         stun_q <= 8'd0;
         mel_q  <= 8'd0;
         cd_q   <= 8'd0;
         div_q  <= 8'd0;
         a_q    <= 1'b0;
         b_q    <= 1'b0;
         ff_q   <= 1'b0;
         mact_q <= 1'b0;
         ko_q   <= 1'b0;
      end else begin
         ff_q <= 1'b0;
         if (tick) begin
            x_q    <= x_n;
            dir_q  <= dir_n;
            y_q    <= y_n;
            vy_q   <= vy_n;
            st_q   <= st_n;
            hp_q   <= hp_n;
            stun_q <= stun_n;
            mel_q  <= mel_n;
            cd_q   <= cd_n;
            div_q  <= div_n;
            a_q    <= a;
            b_q    <= b;
            ff_q   <= fire_n;
            mact_q <= (st_n == MELEE_L) || (st_n == MELEE_R);
            ko_q   <= (st_n == KO);
         end
      end
   end

   assign x             = x_q;
   assign y             = y_q;
   assign state         = st_q;
   assign direction     = dir_q;
   assign fireball_fire = ff_q;
   assign melee_active  = mact_q;
   assign health        = hp_q;
   assign ko            = ko_q;

endmodule

// File: tb/tb_fighter_ctrl.sv
// Directed bench for fighter_ctrl: reset, jump arc, hit-stun, block/KO,
// fireball cooldown, melee and walking boundaries with default parameters.
module tb_fighter_ctrl;
   logic clk = 1'b0, start_n = 1'b0, tick = 1'b0;
   logic left = 0, right = 0, up = 0, down = 0, a = 0, b = 0;
   logic hit_fireball = 0, hit_melee = 0, player_number = 1'b1;
   logic [9:0] x, y;
   logic [2:0] state;
   logic       direction, fireball_fire, melee_active, ko;
   logic [7:0] health;
   int checks = 0, failures = 0;

   fighter_ctrl dut (
      .clk(clk), .start_n(start_n), .tick(tick), .left(left), .right(right), .up(up),
      .down(down), .a(a), .b(b), .hit_fireball(hit_fireball), .hit_melee(hit_melee),
      .player_number(player_number), .x(x), .y(y), .state(state), .direction(direction),
      .fireball_fire(fireball_fire), .melee_active(melee_active), .health(health), .ko(ko)
   );

   always #5 clk = ~clk;

   task automatic do_reset;
      start_n = 0; tick = 0; left = 0; right = 0; up = 0; down = 0; a = 0; b = 0;
      hit_fireball = 0; hit_melee = 0;
      repeat (2) @(negedge clk);
      start_n = 1;
   endtask

   // Called on a falling edge; returns on the next falling edge after one tick.
   task automatic step_tick;
      tick = 1;
      @(negedge clk);
      tick = 0;
   endtask

   task automatic test_reset;
      player_number = 1; do_reset;
      checks++; if (x !== 10'd10) begin failures++; $display("FAIL reset_x got %0d exp 10", x); end
      checks++; if (y !== 10'd100) begin failures++; $display("FAIL reset_y got %0d exp 100", y); end
      checks++; if (direction !== 1'b1) begin failures++; $display("FAIL reset_dir got %0d exp 1", direction); end
      checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got %0d exp 0", state); end
      checks++; if (health !== 8'd100) begin failures++; $display("FAIL reset_health got %0d exp 100", health); end
      checks++; if ({ko, fireball_fire, melee_active} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b exp 000", {ko, fireball_fire, melee_active}); end
      player_number = 0; do_reset;
      checks++; if (x !== 10'd107) begin failures++; $display("FAIL reset_p0_x got %0d exp 107", x); end
      checks++; if (direction !== 1'b0) begin failures++; $display("FAIL reset_p0_dir got %0d exp 0", direction); end
      player_number = 1;
   endtask

   task automatic test_jump;
      int ys[15] = '{93, 87, 82, 78, 75, 73, 72, 72, 73, 75, 78, 82, 87, 93, 100};
      do_reset;
      for (int i = 0; i < 15; i++) begin
         up = (i == 0);
         step_tick;
         checks++; if (y !== 10'(ys[i])) begin failures++; $display("FAIL jump_y[%0d] got %0d exp %0d", i, y, ys[i]); end
         checks++; if (state !== ((i < 14) ? 3'd1 : 3'd0)) begin failures++; $display("FAIL jump_state[%0d] got %0d exp %0d", i, state, (i < 14) ? 1 : 0); end
      end
      checks++; if (x !== 10'd10) begin failures++; $display("FAIL jump_x got %0d exp 10", x); end
      up = 1; step_tick; up = 0; step_tick; step_tick;
      start_n = 0; @(negedge clk); start_n = 1;
      checks++; if ({y, state} !== {10'd100, 3'd0}) begin failures++; $display("FAIL jump_reset y/state got %0d/%0d exp 100/0", y, state); end
   endtask

   task automatic test_hit_stun;
      do_reset;
      hit_fireball = 1; step_tick; hit_fireball = 0;
      checks++; if (health !== 8'd90) begin failures++; $display("FAIL hit_health got %0d exp 90", health); end
      checks++; if (x !== 10'd6) begin failures++; $display("FAIL hit_x got %0d exp 6", x); end
      checks++; if (state !== 3'd5) begin failures++; $display("FAIL hit_state got %0d exp 5", state); end
      for (int i = 0; i < 4; i++) begin
         step_tick;
         checks++; if (state !== 3'd5) begin failures++; $display("FAIL stun_state[%0d] got %0d exp 5", i, state); end
      end
      hit_fireball = 1; step_tick; hit_fireball = 0;
      checks++; if ({health, x} !== {8'd80, 10'd2}) begin failures++; $display("FAIL rehit health/x got %0d/%0d exp 80/2", health, x); end
      for (int i = 1; i <= 12; i++) begin
         step_tick;
         checks++; if (state !== ((i < 12) ? 3'd5 : 3'd0)) begin failures++; $display("FAIL restun_state[%0d] got %0d exp %0d", i, state, (i < 12) ? 5 : 0); end
      end
      hit_fireball = 1; step_tick; hit_fireball = 0;
      checks++; if ({health, x} !== {8'd70, 10'd1}) begin failures++; $display("FAIL clamp_hit health/x got %0d/%0d exp 70/1", health, x); end
   endtask

   task automatic test_block_ko;
      do_reset;
      down = 1; step_tick;
      checks++; if (state !== 3'd2) begin failures++; $display("FAIL crouch_state got %0d exp 2", state); end
      hit_melee = 1; step_tick; hit_melee = 0;
      checks++; if ({health, state, x} !== {8'd99, 3'd6, 10'd10}) begin failures++; $display("FAIL block h/s/x got %0d/%0d/%0d exp 99/6/10", health, state, x); end
      step_tick; down = 0;
      checks++; if (state !== 3'd2) begin failures++; $display("FAIL after_block_state got %0d exp 2", state); end
      do_reset;
      hit_fireball = 1;
      repeat (9) step_tick;
      checks++; if ({health, state, ko} !== {8'd10, 3'd5, 1'b0}) begin failures++; $display("FAIL pre_ko h/s/ko got %0d/%0d/%0d exp 10/5/0", health, state, ko); end
      step_tick; hit_fireball = 0;
      checks++; if ({health, state, ko} !== {8'd0, 3'd7, 1'b1}) begin failures++; $display("FAIL ko h/s/ko got %0d/%0d/%0d exp 0/7/1", health, state, ko); end
      right = 1; up = 1; a = 1;
      repeat (3) step_tick;
      checks++; if ({x, y, state, health, ko, fireball_fire} !== {10'd1, 10'd100, 3'd7, 8'd0, 1'b1, 1'b0}) begin
         failures++; $display("FAIL ko_frozen x/y/s/h/ko/ff got %0d/%0d/%0d/%0d/%0d/%0d exp 1/100/7/0/1/0", x, y, state, health, ko, fireball_fire); end
      right = 0; up = 0; a = 0;
   endtask

   task automatic test_fireball;
      do_reset;
      for (int t = 0; t <= 30; t++) begin
         a = (t == 0 || t == 5 || t == 30);
         step_tick;
         checks++; if (fireball_fire !== (t == 0 || t == 30)) begin failures++; $display("FAIL fire_tick[%0d] got %0d exp %0d", t, fireball_fire, (t == 0 || t == 30)); end
         if (t == 0) begin
            @(negedge clk);
            checks++; if (fireball_fire !== 1'b0) begin failures++; $display("FAIL fire_pulse_width got %0d exp 0", fireball_fire); end
         end
      end
      a = 0;
   endtask

   task automatic test_melee;
      do_reset;
      down = 1; b = 1; step_tick;
      checks++; if ({state, melee_active} !== {3'd2, 1'b0}) begin failures++; $display("FAIL crouch_b s/m got %0d/%0d exp 2/0", state, melee_active); end
      down = 0; b = 0; step_tick;
      checks++; if (state !== 3'd0) begin failures++; $display("FAIL stand_state got %0d exp 0", state); end
      right = 1;
      for (int i = 1; i <= 16; i++) begin
         b = (i != 5);
         step_tick;
         checks++; if ({state, melee_active, x} !== {((i <= 15) ? 3'd4 : 3'd0), (i <= 15), 10'd10}) begin
            failures++; $display("FAIL melee[%0d] s/m/x got %0d/%0d/%0d exp %0d/%0d/10", i, state, melee_active, x, (i <= 15) ? 4 : 0, i <= 15); end
      end
      right = 0; b = 0;
      do_reset;
      b = 1; step_tick; b = 0; step_tick;
      hit_melee = 1; step_tick; hit_melee = 0;
      checks++; if ({state, melee_active, health, x} !== {3'd5, 1'b0, 8'd92, 10'd6}) begin
         failures++; $display("FAIL melee_hit s/m/h/x got %0d/%0d/%0d/%0d exp 5/0/92/6", state, melee_active, health, x); end
   endtask

   task automatic test_walk;
      do_reset;
      right = 1; step_tick; right = 0;
      checks++; if ({x, direction} !== {10'd11, 1'b1}) begin failures++; $display("FAIL walk_r x/d got %0d/%0d exp 11/1", x, direction); end
      left = 1; step_tick;
      checks++; if ({x, direction} !== {10'd10, 1'b0}) begin failures++; $display("FAIL walk_l x/d got %0d/%0d exp 10/0", x, direction); end
      down = 1; step_tick;
      checks++; if ({x, state} !== {10'd10, 3'd2}) begin failures++; $display("FAIL crouch_walk1 x/s got %0d/%0d exp 10/2", x, state); end
      step_tick;
      checks++; if (x !== 10'd9) begin failures++; $display("FAIL crouch_walk2 x got %0d exp 9", x); end
      down = 0; left = 0;
      do_reset;
      left = 1; repeat (12) step_tick; left = 0;
      checks++; if (x !== 10'd1) begin failures++; $display("FAIL clamp_min x got %0d exp 1", x); end
      player_number = 0; do_reset;
      right = 1; repeat (25) step_tick; right = 0;
      checks++; if (x !== 10'd127) begin failures++; $display("FAIL clamp_max x got %0d exp 127", x); end
      player_number = 1;
   endtask

   initial begin
      test_reset;
      test_jump;
      test_hit_stun;
      test_block_ko;
      test_fireball;
      test_melee;
      test_walk;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
